// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller and the CPU top level:
// FSM encoding, halt status codes and the architectural reset PC.
package cpu_run_pkg;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_RESET_HOLD = 2'd1;
   localparam logic [1:0] ST_RUN        = 2'd2;
   localparam logic [1:0] ST_HALT       = 2'd3;

   localparam logic [1:0] STATUS_IDLE    = 2'b00;
   localparam logic [1:0] STATUS_SYSCALL = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
   localparam logic [1:0] STATUS_BADPC   = 2'b11;

   // Must match the reset value of the CPU's PC register.
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } trace_entry_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/run_trace_fifo.sv
// Show-ahead FIFO holding the execution trace; rdata always presents the
// oldest entry, and clear empties it regardless of a same-cycle pop.
module run_trace_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 128
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is accepted when a pop frees the slot this cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle CPU: reset sequencing, state-update
// gating, cycle counting, syscall/limit/bad-PC halting and execution trace.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | after reset; CPU held in reset, waiting for start
// RESET_HOLD  | CPU reset asserted for RESET_CYCLES cycles
// RUN         | CPU executing; cycles counted and traced
// HALT        | run ended; CPU state frozen but readable, status valid
module cpu_run_controller
   import cpu_run_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 2,
   parameter logic [31:0] MAX_CYCLES   = 32'd50000,
   parameter int          TRACE_DEPTH  = 128,
   parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] cpu_pc,
   input  logic [31:0] cpu_instruction,
   input  logic        cpu_syscall,
   output logic        cpu_reset,
   output logic        cpu_enable,
   output logic        running,
   output logic        done,
   output logic [1:0]  status,
   output logic [31:0] cycle_count,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [63:0] trace_data
);

   localparam logic [31:0] TRACE_DEPTH_32 = 32'(TRACE_DEPTH);
   localparam logic [7:0]  HOLD_LOAD      = 8'(RESET_CYCLES - 1);

   logic [1:0]   state;
   logic [7:0]   hold_cnt;
   logic         first_run;
   logic [1:0]   status_r;
   logic [31:0]  cycle_cnt;
   logic         in_run;
   logic         bad_pc;
   logic         commit;
   logic         hit_limit;
   logic         trace_push;
   logic         trace_pop;
   logic         trace_clear;
   logic         fifo_full;
   logic         fifo_empty;
   trace_entry_t trace_entry;

   assign in_run    = (state == ST_RUN);
   assign bad_pc    = in_run && first_run && (cpu_pc != PC_RESET);
   assign commit    = in_run && !bad_pc;
   assign hit_limit = (cycle_cnt == MAX_CYCLES - 32'd1);

   assign trace_clear = start && ((state == ST_IDLE) || (state == ST_HALT));
   // cycle_cnt equals the number of entries captured so far this run.
   assign trace_push  = commit && !fifo_full && (cycle_cnt < TRACE_DEPTH_32);
   assign trace_pop   = trace_valid && trace_ready;
   assign trace_entry = '{pc: cpu_pc, instr: cpu_instruction};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         first_run <= 1'b0;
         status_r  <= STATUS_IDLE;
         cycle_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state     <= ST_RESET_HOLD;
                  hold_cnt  <= HOLD_LOAD;
                  status_r  <= STATUS_IDLE;
                  cycle_cnt <= '0;
               end
            end
            ST_RESET_HOLD: begin
               if (hold_cnt == '0) begin
                  state     <= ST_RUN;
                  first_run <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            ST_RUN: begin
               first_run <= 1'b0;
               if (bad_pc) begin
                  state    <= ST_HALT;
                  status_r <= STATUS_BADPC;
               end else begin
                  cycle_cnt <= sat_inc32(cycle_cnt);
                  // Syscall outranks the cycle limit on the same cycle.
                  if (cpu_syscall) begin
                     state    <= ST_HALT;
                     status_r <= STATUS_SYSCALL;
                  end else if (hit_limit) begin
                     state    <= ST_HALT;
                     status_r <= STATUS_TIMEOUT;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cpu_reset   = (state == ST_IDLE) || (state == ST_RESET_HOLD);
   // The syscall instruction itself must not commit any CPU state.
   assign cpu_enable  = commit && !cpu_syscall;
   assign running     = in_run;
   assign done        = (state == ST_HALT);
   assign status      = status_r;
   assign cycle_count = cycle_cnt;
   assign trace_valid = !fifo_empty;

   run_trace_fifo #(
      .WIDTH (64),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .clock (clock),
      .reset (reset),
      .clear (trace_clear),
      .push  (trace_push),
      .pop   (trace_pop),
      .wdata (trace_entry),
      .rdata (trace_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
